// File: rtl/arm_mult_seq.sv
// Iterative MUL/MLA/xMULL/xMLAL unit: consumes BITS_PER_CYC multiplier bits per cycle,
// with optional early termination, cpu_en stall and synchronous abort.
module arm_mult_seq #(
  parameter int DATA_W       = 32,
  parameter int BITS_PER_CYC = 8,
  parameter bit EARLY_TERM   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              start,
  input  logic              op_long,
  input  logic              op_signed,
  input  logic              op_acc,
  input  logic [DATA_W-1:0] rm,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              flag_n,
  output logic              flag_z
);

  localparam int N_ITER = DATA_W / BITS_PER_CYC;
  localparam int IDX_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int P_W    = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [P_W-1:0]    mcand;
  logic [P_W-1:0]    sum;
  logic [DATA_W-1:0] mplier;
  logic [IDX_W-1:0]  idx;
  logic              op_long_q;
  logic              sgn_q;

  logic              fill;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] rest;
  logic [P_W-1:0]    partial;
  logic [P_W-1:0]    correction;
  logic [P_W-1:0]    next_sum;
  logic              last;

  // The multiplier shifts right each step with sign fill in signed-long mode; on the last
  // step a negative multiplier's upper weight is removed by subtracting mcand << B.
  always_comb begin
    fill       = sgn_q & mplier[DATA_W-1];
    shifted    = $signed({fill, mplier}) >>> BITS_PER_CYC;
    rest       = shifted[DATA_W-1:0];
    partial    = mcand * {{(P_W-BITS_PER_CYC){1'b0}}, mplier[BITS_PER_CYC-1:0]};
    correction = '0;
    last       = (idx == IDX_W'(N_ITER - 1)) ||
                 (EARLY_TERM && ((rest == '0) || (sgn_q && (rest == '1))));
    if (last && fill) begin
      correction = mcand << BITS_PER_CYC;
    end
    next_sum   = sum + partial - correction;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_hi    <= '0;
      res_lo    <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      mcand     <= '0;
      sum       <= '0;
      mplier    <= '0;
      idx       <= '0;
      op_long_q <= 1'b0;
      sgn_q     <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            mcand     <= (op_signed && op_long) ? {{DATA_W{rm[DATA_W-1]}}, rm}
                                                : {{DATA_W{1'b0}}, rm};
            mplier    <= rs;
            idx       <= '0;
            op_long_q <= op_long;
            sgn_q     <= op_signed & op_long;
            sum       <= !op_acc ? '0
                       : (op_long ? {acc_hi, acc_lo} : {{DATA_W{1'b0}}, acc_lo});
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cpu_en) begin
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (op_long_q) begin
                res_hi <= next_sum[P_W-1:DATA_W];
                res_lo <= next_sum[DATA_W-1:0];
                flag_n <= next_sum[P_W-1];
                flag_z <= (next_sum == '0);
              end else begin
                res_hi <= '0;
                res_lo <= next_sum[DATA_W-1:0];
                flag_n <= next_sum[DATA_W-1];
                flag_z <= (next_sum[DATA_W-1:0] == '0);
              end
            end else begin
              idx    <= idx + 1'b1;
              sum    <= next_sum;
              mcand  <= mcand << BITS_PER_CYC;
              mplier <= rest;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mult_seq.sv
// Bench for arm_mult_seq: table vectors, random ops against an arithmetic model, and
// hand sequences for stall, abort, back-to-back and asynchronous reset.
module tb_arm_mult_seq;

  localparam int W = 32;
  localparam int B = 8;
  localparam int NI = W / B;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_en = 1'b1;
  logic start = 1'b0;
  logic op_long = 1'b0;
  logic op_signed = 1'b0;
  logic op_acc = 1'b0;
  logic abort = 1'b0;
  logic [W-1:0] rm = '0, rs = '0, acc_hi = '0, acc_lo = '0;

  logic busy, done, flag_n, flag_z;
  logic [W-1:0] res_hi, res_lo;
  logic busy_ne, done_ne, flag_n_ne, flag_z_ne;
  logic [W-1:0] res_hi_ne, res_lo_ne;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arm_mult_seq #(.DATA_W(W), .BITS_PER_CYC(B), .EARLY_TERM(1'b1)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .start(start), .op_long(op_long),
    .op_signed(op_signed), .op_acc(op_acc), .rm(rm), .rs(rs), .acc_hi(acc_hi),
    .acc_lo(acc_lo), .abort(abort), .busy(busy), .done(done), .res_hi(res_hi),
    .res_lo(res_lo), .flag_n(flag_n), .flag_z(flag_z));

  arm_mult_seq #(.DATA_W(W), .BITS_PER_CYC(B), .EARLY_TERM(1'b0)) dut_ne (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .start(start), .op_long(op_long),
    .op_signed(op_signed), .op_acc(op_acc), .rm(rm), .rs(rs), .acc_hi(acc_hi),
    .acc_lo(acc_lo), .abort(abort), .busy(busy_ne), .done(done_ne), .res_hi(res_hi_ne),
    .res_lo(res_lo_ne), .flag_n(flag_n_ne), .flag_z(flag_z_ne));

  typedef struct {
    logic [W-1:0] rm, rs, ah, al;
    logic         lng, sgn, acc;
    logic [63:0]  exp_res;
    logic         exp_n, exp_z;
    int           exp_k;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: full-width product plus accumulate, modulo 2^64
  function automatic logic [63:0] model_p(input logic [W-1:0] a_rm, a_rs, a_hi, a_lo,
                                          input logic lng, sgn, acc);
    logic [63:0] a, b, p;
    if (sgn && lng) begin
      a = {{W{a_rm[W-1]}}, a_rm};
      b = {{W{a_rs[W-1]}}, a_rs};
    end else begin
      a = {32'b0, a_rm};
      b = {32'b0, a_rs};
    end
    p = a * b;
    if (acc) p = p + (lng ? {a_hi, a_lo} : {32'b0, a_lo});
    return p;
  endfunction

  function automatic int model_k(input logic [W-1:0] a_rs, input logic lng, sgn);
    for (int n = 1; n < NI; n++) begin
      if ((a_rs >> (n * B)) == 0) return n;
      if (sgn && lng && (($signed(a_rs) >>> (n * B)) == -1)) return n;
    end
    return NI;
  endfunction

  task automatic apply_stimulus(input logic [W-1:0] a_rm, a_rs, a_hi, a_lo,
                                input logic lng, sgn, acc);
    rm = a_rm; rs = a_rs; acc_hi = a_hi; acc_lo = a_lo;
    op_long = lng; op_signed = sgn; op_acc = acc;
  endtask

  // Starts one op, waits for both instances, checks latency, one-cycle pulse and result.
  task automatic run_op(input string name, input logic [W-1:0] a_rm, a_rs, a_hi, a_lo,
                        input logic lng, sgn, acc, input logic [63:0] exp_res,
                        input logic exp_n, exp_z, input int exp_k,
                        input int stall_at, input int stall_len);
    int got_k, got_k_ne, pulses, pulses_ne;
    logic [63:0] r, r_ne;
    logic fn, fz, fn_ne, fz_ne;
    got_k = -1; got_k_ne = -1; pulses = 0; pulses_ne = 0;
    r = '0; r_ne = '0; fn = 0; fz = 0; fn_ne = 0; fz_ne = 0;
    apply_stimulus(a_rm, a_rs, a_hi, a_lo, lng, sgn, acc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output({name, " busy"}, {63'b0, busy}, 64'd1);
    for (int c = 1; c <= 40 && (got_k < 0 || got_k_ne < 0); c++) begin
      @(posedge clk); #1;
      if (c == stall_at) cpu_en = 1'b0;
      if (stall_len > 0 && c == stall_at + stall_len) cpu_en = 1'b1;
      if (stall_len > 0 && c > stall_at && c < stall_at + stall_len)
        check_output({name, " busy_stall"}, {63'b0, busy}, 64'd1);
      if (done) begin
        pulses++;
        if (got_k < 0) begin
          got_k = c; r = {res_hi, res_lo}; fn = flag_n; fz = flag_z;
        end
      end
      if (done_ne) begin
        pulses_ne++;
        if (got_k_ne < 0) begin
          got_k_ne = c; r_ne = {res_hi_ne, res_lo_ne}; fn_ne = flag_n_ne; fz_ne = flag_z_ne;
        end
      end
    end
    cpu_en = 1'b1;
    @(posedge clk); #1;
    if (done) pulses++;
    if (done_ne) pulses_ne++;
    check_int({name, " k"}, got_k, exp_k + stall_len);
    check_int({name, " k_ne"}, got_k_ne, NI + stall_len);
    check_int({name, " pulses"}, pulses + pulses_ne, 2);
    check_output({name, " res"}, r, exp_res);
    check_output({name, " res_ne"}, r_ne, exp_res);
    check_output({name, " flags"}, {62'b0, fn, fz}, {62'b0, exp_n, exp_z});
    check_output({name, " flags_ne"}, {62'b0, fn_ne, fz_ne}, {62'b0, exp_n, exp_z});
    check_output({name, " idle_busy"}, {62'b0, busy, busy_ne}, 64'd0);
  endtask

  task automatic run_model(input string name, input logic [W-1:0] a_rm, a_rs, a_hi, a_lo,
                           input logic lng, sgn, acc);
    logic [63:0] p, er;
    logic en, ez;
    p = model_p(a_rm, a_rs, a_hi, a_lo, lng, sgn, acc);
    if (lng) begin
      er = p; en = p[63]; ez = (p == 0);
    end else begin
      er = {32'b0, p[31:0]}; en = p[31]; ez = (p[31:0] == 0);
    end
    run_op(name, a_rm, a_rs, a_hi, a_lo, lng, sgn, acc, er, en, ez,
           model_k(a_rs, lng, sgn), 0, 0);
  endtask

  initial begin
    logic [63:0] prev, prev_ne;
    logic [W-1:0] mask, r_rm, r_rs;
    logic l, s, a;
    int seen;

    vecs[0] = '{32'd7, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'd35, 1'b0, 1'b0, 1};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0,
                64'hFFFFFFFE_00000001, 1'b1, 1'b0, 4};
    vecs[3] = '{32'd3, 32'd4, 32'h12345678, 32'hFFFFFFF4, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 1};
    vecs[4] = '{32'hFFFFFFFE, 32'd3, 32'd0, 32'd5, 1'b1, 1'b1, 1'b1,
                64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 4};
    vecs[6] = '{32'd3, 32'h01000000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 64'h03000000, 1'b0, 1'b0, 4};
    vecs[7] = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1};
    vecs[8] = '{32'd1, 32'h80000000, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0,
                64'hFFFFFFFF_80000000, 1'b1, 1'b0, 4};
    vecs[9] = '{32'h10, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'h12340, 1'b0, 1'b0, 2};

    #2;
    check_output("reset_outputs", {busy, done, flag_n, flag_z, res_hi, res_lo},
                 {4'b0, 64'd0});
    check_output("reset_outputs_ne", {busy_ne, done_ne, flag_n_ne, flag_z_ne, res_hi_ne, res_lo_ne},
                 {4'b0, 64'd0});
    #10 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].rm, vecs[i].rs, vecs[i].ah, vecs[i].al,
             vecs[i].lng, vecs[i].sgn, vecs[i].acc, vecs[i].exp_res,
             vecs[i].exp_n, vecs[i].exp_z, vecs[i].exp_k, 0, 0);
    end

    run_op("stall", 32'd5, 32'h01000000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0,
           64'h05000000, 1'b0, 1'b0, 4, 2, 3);

    for (int i = 0; i < 30; i++) begin
      mask = 32'hFFFFFFFF >> (8 * $urandom_range(0, 3));
      l = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1));
      r_rm = $urandom;
      r_rs = $urandom & mask;
      if (s && $urandom_range(0, 1) == 1) r_rs = r_rs | ~mask;
      run_model($sformatf("rand%0d", i), r_rm, r_rs, $urandom, $urandom, l, s, a);
    end

    // Abort two edges into a four-iteration op: no done, results untouched
    prev = {res_hi, res_lo};
    prev_ne = {res_hi_ne, res_lo_ne};
    apply_stimulus(32'd9, 32'h01000000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_output("abort_busy", {62'b0, busy, busy_ne}, 64'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || done_ne) seen++;
    end
    check_int("abort_no_done", seen, 0);
    check_output("abort_res", {res_hi, res_lo}, prev);
    check_output("abort_res_ne", {res_hi_ne, res_lo_ne}, prev_ne);

    // Abort in the same edge as a single-iteration completion
    apply_stimulus(32'd7, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_output("abort_vs_done", {62'b0, done, busy}, 64'd0);
    check_output("abort_vs_done_res", {res_hi, res_lo}, prev);

    // start together with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_output("abort_start_idle", {62'b0, busy, busy_ne}, 64'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || done_ne || busy || busy_ne) seen++;
    end
    check_int("abort_start_quiet", seen, 0);

    // Back-to-back: second start accepted in the DONE cycle
    apply_stimulus(32'd7, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_output("b2b_first", {31'b0, done, res_lo}, {31'b0, 1'b1, 32'd35});
    apply_stimulus(32'd3, 32'h100, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("b2b_done_drop", {62'b0, done, busy}, 64'd1);
    @(posedge clk); #1;
    check_output("b2b_mid", {63'b0, done}, 64'd0);
    @(posedge clk); #1;
    check_output("b2b_second", {31'b0, done, res_lo}, {31'b0, 1'b1, 32'h300});
    @(posedge clk); #1;
    check_output("b2b_pulse_end", {63'b0, done}, 64'd0);
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset mid-run clears outputs without a clock edge
    apply_stimulus(32'd11, 32'h01000000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("rst_mid_run", {busy, done, flag_n, flag_z, res_hi, res_lo}, {4'b0, 64'd0});
    check_output("rst_mid_run_ne", {busy_ne, done_ne, flag_n_ne, flag_z_ne, res_hi_ne, res_lo_ne},
                 {4'b0, 64'd0});
    @(posedge clk); #2;
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || done_ne || busy || busy_ne) seen++;
    end
    check_int("rst_discards_op", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
